im_access_arbiter: RTL and testbench
====================================

// Module: im_access_arbiter
//
// PURPOSE
//   Shares the single-port instruction memory between two requesters.
//   - Fetch: CPU instruction fetch, read-only.
//   - Load: program loader, write-only.
//   Grants at most one IM access per cycle. Fetch has priority, but a starvation counter
//   guarantees the loader a slot. Returns fetch read data with a registered valid strobe,
//   aligned to the IM's one-cycle registered read. Sits between the core/loader and the IM.
//
// PARAMETERS
//   ADDRWIDTH   16  IM word-address width
//   DATAWIDTH   32  IM data width
//   MAX_STARVE  4   max consecutive fetch grants while load_req is pending (>=1)
//
// PORTS
//   clk           in   1          clock
//   rst           in   1          reset, asynchronous, active-high
//   fetch_req     in   1          fetch read request, held until granted
//   fetch_addr    in   ADDRWIDTH  fetch word address
//   fetch_gnt     out  1          fetch request accepted this cycle
//   fetch_rvalid  out  1          fetch_rdata valid, 1 cycle after fetch_gnt
//   fetch_rdata   out  DATAWIDTH  read data (passthrough of IM_out)
//   load_req      in   1          loader write request, held until granted
//   load_addr     in   ADDRWIDTH  loader word address
//   load_wdata    in   DATAWIDTH  loader write data
//   load_gnt      out  1          loader write accepted this cycle
//   IM_enable     out  1          IM access strobe
//   IM_write      out  1          1 = write, 0 = read
//   IM_address    out  ADDRWIDTH  IM address
//   IM_in         out  DATAWIDTH  IM write data
//   IM_out        in   DATAWIDTH  IM registered read data
//
// BEHAVIOUR
//   - Reset (rst high, async):
//     - starve_cnt = 0, fetch_rvalid = 0.
//     - fetch_gnt, load_gnt, IM_enable and IM_write are forced to 0 while rst is high.
//     - IM_address and IM_in are driven to 0.
//   - Arbitration is combinational from the request inputs and starve_cnt:
//     - Only fetch_req: fetch_gnt = 1.
//     - Only load_req: load_gnt = 1.
//     - Both requests: load wins iff starve_cnt == MAX_STARVE, otherwise fetch wins.
//     - Neither request: no grant, IM_enable = 0, IM_address and IM_in = 0.
//     - fetch_gnt and load_gnt are never asserted together.
//   - IM drive:
//     - IM_enable = fetch_gnt | load_gnt.
//     - IM_write = load_gnt.
//     - IM_address = granted requester's address.
//     - IM_in = load_wdata when load_gnt, else 0.
//   - Handshake:
//     - A request is consumed on the clk edge where its gnt is 1.
//     - The requester may change address/data or drop req in the following cycle.
//   - starve_cnt (registered, width clog2(MAX_STARVE+1)), updated every cycle:
//     - load_gnt: cleared to 0.
//     - fetch_gnt and load_req: increment, saturating at MAX_STARVE.
//     - Otherwise (load_req low): cleared to 0.
//   - Read return:
//     - fetch_rvalid is a register loaded with fetch_gnt.
//     - fetch_rdata = IM_out; it is only meaningful while fetch_rvalid = 1.
//     - Read latency is exactly 1 cycle from grant; back-to-back fetches give rvalid every cycle.
//   - Read-after-write: a load granted in cycle n followed by a fetch of the same address
//     in cycle n+1 returns the new data in cycle n+2. No bypass is needed.
//   - Reset mid-operation: a fetch granted in the cycle before rst rises produces no rvalid.
//     The requester re-issues after reset.
//
// TESTING
//   1. Reset: rst=1 with both reqs high -> all grants, IM_enable and fetch_rvalid = 0.
//      After release -> starve_cnt = 0.
//   2. Load only: load_req held 3 cycles at addrs 0x0000..0x0002, data 0x11,0x22,0x33
//      -> load_gnt=1 and IM_write=1 each cycle; starve_cnt stays 0.
//   3. Fetch only: fetch_addr 0x0001 after test 2 -> fetch_gnt same cycle,
//      fetch_rvalid=1 next cycle, fetch_rdata=0x22.
//   4. RAW: load 0x0004<=0xDEADBEEF in cycle n, fetch 0x0004 in n+1
//      -> rvalid in n+2 with 0xDEADBEEF.
//   5. Contention (MAX_STARVE=4), both reqs held 10 cycles
//      -> grant order F,F,F,F,L,F,F,F,F,L; never two grants in one cycle.
//   6. Reset mid-read: fetch granted in cycle n, rst asserted in n+1
//      -> fetch_rvalid stays 0 throughout.

Source files
------------

// File: rtl/im_access_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters
// (CPU fetch and program loader) and the single-port instruction memory.
interface im_access_arbiter_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    // Fetch requester (read-only)
    logic                 fetch_req;
    logic [ADDRWIDTH-1:0] fetch_addr;
    logic                 fetch_gnt;
    logic                 fetch_rvalid;
    logic [DATAWIDTH-1:0] fetch_rdata;

    // Load requester (write-only)
    logic                 load_req;
    logic [ADDRWIDTH-1:0] load_addr;
    logic [DATAWIDTH-1:0] load_wdata;
    logic                 load_gnt;

    // Instruction memory port
    logic                 IM_enable;
    logic                 IM_write;
    logic [ADDRWIDTH-1:0] IM_address;
    logic [DATAWIDTH-1:0] IM_in;
    logic [DATAWIDTH-1:0] IM_out;

    // Arbiter side
    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_wdata, IM_out,
        output fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt,
               IM_enable, IM_write, IM_address, IM_in
    );

    // Requesters and memory side
    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_wdata, IM_out,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt,
               IM_enable, IM_write, IM_address, IM_in
    );
endinterface

// File: rtl/im_access_arbiter.sv
// Instruction-memory access arbiter: one IM access per cycle, fetch has
// priority, a starvation counter guarantees the loader a slot after
// MAX_STARVE consecutive fetch grants. Fetch read data returns one cycle
// after grant, aligned with the IM's registered read.
module im_access_arbiter #(
    parameter int ADDRWIDTH  = 16,
    parameter int DATAWIDTH  = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                rst,
    im_access_arbiter_if.slave  bus
);

    localparam int            CNT_W     = $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

    logic [CNT_W-1:0]     starve_cnt;
    logic                 fetch_rvalid_p1;
    logic                 fetch_gnt;
    logic                 load_gnt;
    logic                 im_enable;
    logic                 im_write;
    logic [ADDRWIDTH-1:0] im_address;
    logic [DATAWIDTH-1:0] im_in;

    // Increment that holds at the starvation limit
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == STARVE_MAX) return v;
        return v + CNT_W'(1);
    endfunction

    // Grant selection: fetch first unless the loader has waited MAX_STARVE grants
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!rst) begin
            if (bus.fetch_req && bus.load_req) begin
                if (starve_cnt == STARVE_MAX) load_gnt  = 1'b1;
                else                          fetch_gnt = 1'b1;
            end else if (bus.fetch_req) begin
                fetch_gnt = 1'b1;
            end else if (bus.load_req) begin
                load_gnt = 1'b1;
            end
        end
    end

    // IM port drive from the winning requester; quiet bus when idle
    always_comb begin
        im_enable  = 1'b0;
        im_write   = 1'b0;
        im_address = '0;
        im_in      = '0;
        if (load_gnt) begin
            im_enable  = 1'b1;
            im_write   = 1'b1;
            im_address = bus.load_addr;
            im_in      = bus.load_wdata;
        end else if (fetch_gnt) begin
            im_enable  = 1'b1;
            im_address = bus.fetch_addr;
        end
    end

    // Count fetch grants won against a waiting loader; clear once it is served or leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (load_gnt) begin
            starve_cnt <= '0;
        end else if (fetch_gnt && bus.load_req) begin
            starve_cnt <= sat_inc(starve_cnt);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Read-return strobe: one cycle behind the fetch grant, matching the IM read register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_rvalid_p1 <= 1'b0;
        else     fetch_rvalid_p1 <= fetch_gnt;
    end

    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.load_gnt     = load_gnt;
    assign bus.fetch_rvalid = fetch_rvalid_p1;
    assign bus.fetch_rdata  = bus.IM_out;
    assign bus.IM_enable    = im_enable;
    assign bus.IM_write     = im_write;
    assign bus.IM_address   = im_address;
    assign bus.IM_in        = im_in;

endmodule

// File: tb/tb_im_access_arbiter.sv
// Scoreboard bench for im_access_arbiter: stimulus pushes expected grants and
// read data into queues, a negedge monitor pops and compares them.
module tb_im_access_arbiter;

    typedef struct {
        bit          is_load;
        logic [15:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    im_access_arbiter_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus ();

    im_access_arbiter #(.ADDRWIDTH(16), .DATAWIDTH(32), .MAX_STARVE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    gnt_t        gq[$];
    logic [31:0] rq[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic        prev_fgnt = 1'b0;
    logic [31:0] mem [0:255];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic miss(input string name, input string what);
        total_cnt++;
        $display("FAIL %s: actual=%s required=none (t=%0t)", name, what, $time);
    endtask

    // Single-port IM with registered read
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (bus.IM_enable) begin
            if (bus.IM_write) mem[bus.IM_address[7:0]] <= bus.IM_in;
            else              bus.IM_out <= mem[bus.IM_address[7:0]];
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_fetch_gnt", bus.fetch_gnt, 0);
            chk("rst_load_gnt", bus.load_gnt, 0);
            chk("rst_im_enable", bus.IM_enable, 0);
            chk("rst_im_write", bus.IM_write, 0);
            chk("rst_fetch_rvalid", bus.fetch_rvalid, 0);
            prev_fgnt = 1'b0;
        end else begin
            chk("rvalid_latency", bus.fetch_rvalid, prev_fgnt);
            if (bus.fetch_rvalid) begin
                if (rq.size() == 0) miss("rdata_unexpected", "rvalid");
                else chk("fetch_rdata", bus.fetch_rdata, rq.pop_front());
            end
            if (bus.fetch_gnt && bus.load_gnt) begin
                miss("double_grant", "both");
            end else if (bus.fetch_gnt || bus.load_gnt) begin
                if (gq.size() == 0) begin
                    miss("grant_unexpected", bus.load_gnt ? "load" : "fetch");
                end else begin
                    gnt_t e;
                    e = gq.pop_front();
                    chk("gnt_is_load", bus.load_gnt, e.is_load);
                    chk("im_enable", bus.IM_enable, 1);
                    chk("im_write", bus.IM_write, e.is_load);
                    chk("im_address", bus.IM_address, e.addr);
                    chk("im_in", bus.IM_in, e.wdata);
                end
            end else begin
                chk("idle_im_bus", {bus.IM_enable, bus.IM_write, bus.IM_address, bus.IM_in}, 0);
            end
            prev_fgnt = bus.fetch_gnt;
        end
    end

    task automatic push_gnt(input bit is_load, input logic [15:0] a, input logic [31:0] d);
        gnt_t e;
        e.is_load = is_load;
        e.addr    = a;
        e.wdata   = is_load ? d : 32'h0;
        gq.push_back(e);
    endtask

    task automatic drive(input logic fr, input logic [15:0] fa,
                         input logic lr, input logic [15:0] la, input logic [31:0] ld);
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.load_req   = lr;
        bus.load_addr  = la;
        bus.load_wdata = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: reset with both requests high
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h0003;
        bus.load_req   = 1'b1;
        bus.load_addr  = 16'h0005;
        bus.load_wdata = 32'h55;
        repeat (3) @(posedge clk);
        #1;
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        rst = 1'b0;
        chk("starve_after_rst", dut.starve_cnt, 0);

        // Test 2: load only, three consecutive writes
        for (int i = 0; i < 3; i++) begin
            push_gnt(1'b1, 16'(i), 32'((i + 1) * 32'h11));
            drive(1'b0, 16'h0, 1'b1, 16'(i), 32'((i + 1) * 32'h11));
            chk("starve_load_only", dut.starve_cnt, 0);
        end

        // Test 3: fetch only from address 1
        push_gnt(1'b0, 16'h0001, 32'h0);
        rq.push_back(32'h22);
        drive(1'b1, 16'h0001, 1'b0, 16'h0, 32'h0);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);

        // Test 4: read-after-write on address 4
        push_gnt(1'b1, 16'h0004, 32'hDEADBEEF);
        drive(1'b0, 16'h0, 1'b1, 16'h0004, 32'hDEADBEEF);
        push_gnt(1'b0, 16'h0004, 32'h0);
        rq.push_back(32'hDEADBEEF);
        drive(1'b1, 16'h0004, 1'b0, 16'h0, 32'h0);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);

        // Test 5: contention for 10 cycles -> F,F,F,F,L,F,F,F,F,L
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                push_gnt(1'b1, 16'(16'h10 + k), 32'(k));
            end else begin
                push_gnt(1'b0, 16'h0002, 32'h0);
                rq.push_back(32'h33);
            end
            drive(1'b1, 16'h0002, 1'b1, 16'(16'h10 + k), 32'(k));
        end
        chk("starve_after_contention", dut.starve_cnt, 0);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);

        // Test 6: reset right after a fetch grant suppresses its rvalid
        push_gnt(1'b0, 16'h0000, 32'h0);
        drive(1'b1, 16'h0000, 1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        bus.fetch_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) drive(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);

        chk("grant_queue_drained", gq.size(), 0);
        chk("rdata_queue_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
